// File: rtl/draw_back_ground.sv
// Ground (horizon) strip pixel classifier for the T-rex VGA renderer.
// Maps the scan coordinate into strip-local art coordinates, evaluates the
// procedural artwork chosen by select, and registers the result (1-cycle latency).
module draw_back_ground #(
    parameter int unsigned ratio = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] ox,
    input  logic [8:0]  oy,
    input  logic [9:0]  X,
    input  logic [9:0]  Y,
    input  logic [3:0]  select,
    output logic        inGrey
);

    // Legal scales are 1, 2 and 4, so the art coordinate is a plain right shift.
    localparam int unsigned Shift  = (ratio >= 4) ? 2 : ((ratio >= 2) ? 1 : 0);
    // Strip width can reach 4800 for ratio 4, so compare in 16 bits.
    localparam logic [15:0] StripW = 16'(1200 * ratio);
    localparam logic [9:0]  StripH = 10'(12 * ratio);

    localparam logic [3:0]  SelPlain    = 4'd0;
    localparam logic [3:0]  SelTextured = 4'd1;

    logic [12:0] dx;
    logic [10:0] dy;
    logic        inside_x;
    logic        inside_y;
    logic [5:0]  u_lo;
    logic [3:0]  v;
    logic        bump;
    logic        in_grey_d;
    logic        in_grey_q;

    // Strip-local offsets; 13-bit dx covers -2047..3071 without wrapping.
    always_comb begin
        dx = {3'b000, X} - {ox[11], ox};
        dy = {1'b0, Y} - {2'b00, oy};
    end

    // Inside test and art-space coordinates; only the low six u bits feed the art.
    always_comb begin
        inside_x = ~dx[12] && ({4'b0000, dx[11:0]} < StripW);
        inside_y = ~dy[10] && (dy[9:0] < StripH);
        u_lo     = dx[Shift +: 6];
        v        = dy[Shift +: 4];
        bump     = (u_lo >= 6'd20) && (u_lo <= 6'd27);
    end

    // Artwork evaluation; anything outside the strip is never grey.
    always_comb begin
        in_grey_d = 1'b0;
        if (inside_x && inside_y) begin
            case (select)
                SelPlain: begin
                    in_grey_d = (v == 4'd1);
                end
                SelTextured: begin
                    in_grey_d = ((v == 4'd0) && bump)
                             || ((v == 4'd1) && !bump)
                             || ((v == 4'd5) && (u_lo[4:0] == 5'd3))
                             || ((v == 4'd9) && ((u_lo == 6'd40) || (u_lo == 6'd41)));
                end
                default: begin
                    in_grey_d = 1'b0;
                end
            endcase
        end
    end

    // Output register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_grey_q <= 1'b0;
        end else begin
            in_grey_q <= in_grey_d;
        end
    end

    assign inGrey = in_grey_q;

endmodule

// File: tb/tb_draw_back_ground.sv
// Self-checking bench for draw_back_ground: two instances (ratio 1 and 2) share
// stimulus; an arithmetic model predicts every registered output each cycle, and
// directed vectors carry hand-computed literals for both DUT and model.
module tb_draw_back_ground;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] ox  = 12'd0;
    logic [8:0]  oy  = 9'd300;
    logic [9:0]  xs  = 10'd5;
    logic [9:0]  ys  = 10'd301;
    logic [3:0]  sel = 4'd0;
    logic        grey1;
    logic        grey2;

    int n_cmp = 0;
    int n_err = 0;

    logic exp1    = 1'b0;
    logic exp2    = 1'b0;
    logic started = 1'b0;

    always #5 clk = ~clk;

    draw_back_ground #(.ratio(1)) u_dut1 (
        .clk(clk), .rst(rst), .ox(ox), .oy(oy), .X(xs), .Y(ys), .select(sel), .inGrey(grey1)
    );

    draw_back_ground #(.ratio(2)) u_dut2 (
        .clk(clk), .rst(rst), .ox(ox), .oy(oy), .X(xs), .Y(ys), .select(sel), .inGrey(grey2)
    );

    // Reference: plain integer geometry, division for scaling, modulo for repeats.
    function automatic logic model(input int r, input logic [11:0] o_x, input logic [8:0] o_y,
                                   input logic [9:0] x_c, input logic [9:0] y_c,
                                   input logic [3:0] s);
        int sox;
        int dxi;
        int dyi;
        int u;
        int v;
        bit b;
        sox = o_x[11] ? (int'(o_x) - 4096) : int'(o_x);
        dxi = int'(x_c) - sox;
        dyi = int'(y_c) - int'(o_y);
        if (dxi < 0 || dxi >= 1200 * r || dyi < 0 || dyi >= 12 * r) return 1'b0;
        u = dxi / r;
        v = dyi / r;
        b = ((u % 64) >= 20) && ((u % 64) <= 27);
        if (s == 4'd0) return (v == 1);
        if (s == 4'd1) begin
            return (v == 0 && b) || (v == 1 && !b) || (v == 5 && (u % 32) == 3)
                || (v == 9 && ((u % 64) == 40 || (u % 64) == 41));
        end
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (ox=%0d oy=%0d X=%0d Y=%0d sel=%0d rst=%b)",
                     name, act, req, ox, oy, xs, ys, sel, rst);
        end
    endtask

    // Model register mirrors the 1-cycle latency and synchronous reset.
    always @(posedge clk) begin
        exp1    <= rst ? 1'b0 : model(1, ox, oy, xs, ys, sel);
        exp2    <= rst ? 1'b0 : model(2, ox, oy, xs, ys, sel);
        started <= 1'b1;
    end

    // Every-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (started) begin
            check("model_r1", grey1, exp1);
            check("model_r2", grey2, exp2);
        end
    end

    // Present one vector, then check the registered result against literals
    // (e < 0 means no literal for that instance).
    task automatic apply(input string name, input logic r, input logic [11:0] o_x,
                         input logic [8:0] o_y, input logic [9:0] x_c, input logic [9:0] y_c,
                         input logic [3:0] s, input int e1, input int e2);
        @(posedge clk);
        #1;
        rst = r;
        ox  = o_x;
        oy  = o_y;
        xs  = x_c;
        ys  = y_c;
        sel = s;
        @(posedge clk);
        @(negedge clk);
        #1;
        if (e1 >= 0) begin
            check({name, "_r1"}, grey1, e1[0]);
            check({name, "_r1_ref"}, exp1, e1[0]);
        end
        if (e2 >= 0) begin
            check({name, "_r2"}, grey2, e2[0]);
            check({name, "_r2_ref"}, exp2, e2[0]);
        end
    endtask

    initial begin
        // Reset held with grey-producing inputs, then released.
        for (int i = 0; i < 3; i++) apply("reset_hold", 1'b1, 12'd0, 9'd300, 10'd5, 10'd301, 4'd0, 0, 0);
        apply("reset_release", 1'b0, 12'd0, 9'd300, 10'd5, 10'd301, 4'd0, 1, 0);

        // Plain horizon rows.
        apply("plain_y301", 1'b0, 12'd0, 9'd300, 10'd5, 10'd301, 4'd0, 1, 0);
        apply("plain_y300", 1'b0, 12'd0, 9'd300, 10'd5, 10'd300, 4'd0, 0, 0);
        apply("plain_y302", 1'b0, 12'd0, 9'd300, 10'd5, 10'd302, 4'd0, 0, 1);
        apply("plain_y299", 1'b0, 12'd0, 9'd300, 10'd5, 10'd299, 4'd0, 0, 0);

        // Signed origin and strip edges.
        apply("ox_m20",      1'b0, 12'hFEC, 9'd300, 10'd0,   10'd301, 4'd0, 1, 0);
        apply("ox600_x599",  1'b0, 12'd600, 9'd300, 10'd599, 10'd301, 4'd0, 0, 0);
        apply("ox600_x600",  1'b0, 12'd600, 9'd300, 10'd600, 10'd301, 4'd0, 1, 0);
        apply("ox_m1200",    1'b0, 12'hB50, 9'd300, 10'd0,   10'd301, 4'd0, 0, 0);
        apply("ox_m1199",    1'b0, 12'hB51, 9'd300, 10'd0,   10'd301, 4'd0, 1, -1);
        apply("ox1024",      1'b0, 12'd1024, 9'd300, 10'd1023, 10'd301, 4'd0, 0, 0);
        apply("ox2047",      1'b0, 12'd2047, 9'd300, 10'd0,  10'd302, 4'd0, 0, 0);

        // Textured horizon.
        apply("tex_20_300", 1'b0, 12'd0, 9'd300, 10'd20, 10'd300, 4'd1, 1, 0);
        apply("tex_19_300", 1'b0, 12'd0, 9'd300, 10'd19, 10'd300, 4'd1, 0, 0);
        apply("tex_20_301", 1'b0, 12'd0, 9'd300, 10'd20, 10'd301, 4'd1, 0, 0);
        apply("tex_19_301", 1'b0, 12'd0, 9'd300, 10'd19, 10'd301, 4'd1, 1, 0);
        apply("tex_3_305",  1'b0, 12'd0, 9'd300, 10'd3,  10'd305, 4'd1, 1, 0);
        apply("tex_41_309", 1'b0, 12'd0, 9'd300, 10'd41, 10'd309, 4'd1, 1, 0);
        apply("tex_42_309", 1'b0, 12'd0, 9'd300, 10'd42, 10'd309, 4'd1, 0, 0);

        // Unused select.
        apply("sel5", 1'b0, 12'd0, 9'd300, 10'd5, 10'd301, 4'd5, 0, 0);

        // Ratio 2 scaling and widened strip.
        apply("r2_y302", 1'b0, 12'd0, 9'd300, 10'd5, 10'd302, 4'd0, 0, 1);
        apply("r2_y303", 1'b0, 12'd0, 9'd300, 10'd5, 10'd303, 4'd0, 0, 1);
        apply("r2_y301", 1'b0, 12'd0, 9'd300, 10'd5, 10'd301, 4'd0, 1, 0);
        apply("r2_y304", 1'b0, 12'd0, 9'd300, 10'd5, 10'd304, 4'd0, 0, 0);
        apply("r2_wide", 1'b0, 12'hB50, 9'd300, 10'd1100, 10'd302, 4'd0, 0, 1);
        apply("r2_last", 1'b0, 12'h800, 9'd300, 10'd351, 10'd302, 4'd0, 0, 1);
        apply("r2_past", 1'b0, 12'h800, 9'd300, 10'd352, 10'd302, 4'd0, 0, 0);

        // Reset asserted mid-line forces 0, then recovery.
        apply("midline_rst", 1'b1, 12'd0, 9'd300, 10'd5, 10'd302, 4'd0, 0, 0);
        apply("after_rst",   1'b0, 12'd0, 9'd300, 10'd5, 10'd302, 4'd0, 0, 1);

        // Inputs changing every cycle; the per-cycle model check covers these.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 49) == 0);
            ox  = 12'($urandom_range(0, 2399) - 1300);
            oy  = 9'($urandom_range(295, 305));
            xs  = 10'($urandom_range(0, 1023));
            ys  = 10'(int'(oy) + $urandom_range(0, 28) - 2);
            sel = 4'($urandom_range(0, 2));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
